vga_mem_fetch: RTL and testbench

Memory-side read/write port that services the VGA writer's pixel requests from ZBT SRAM and interleaves NTSC-capture writes into the idle cycles. It converts the clocked screen coordinate into a double-buffered word address, issues pipelined reads, and returns a 36-bit word (two 18-bit YCrCb pixels) with `done_vga`. It swaps display/capture buffers on frame completion, only during vertical blank.

---
 rtl/vga_mem_fetch_pkg.sv | 27 ++
 rtl/vga_mem_fetch_delay.sv | 27 ++
 rtl/vga_mem_fetch.sv | 117 +++++++++++
 tb/tb_vga_mem_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_fetch_pkg.sv
// Shared widths, screen limits and the per-slot tag type for the VGA memory fetch port.
package vga_mem_fetch_pkg;

    localparam int LOG_MEM    = 36;
    localparam int LOG_HCOUNT = 11;
    localparam int LOG_VCOUNT = 10;
    localparam int ZBT_AW     = 19;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    typedef struct packed {
        logic valid;
        logic is_read;
        logic zero;
    } slot_tag_t;

    // 320 words per line is built from two shifts so no multiplier is needed.
    function automatic logic [ZBT_AW-1:0] line_base(input logic [LOG_VCOUNT-1:0] v,
                                                    input int words);
        logic [ZBT_AW-1:0] v_w;
        v_w = ZBT_AW'(v);
        if (words == 320)
            return (v_w << 8) + (v_w << 6);
        return v_w * ZBT_AW'(words);
    endfunction

endpackage

// File: rtl/vga_mem_fetch_delay.sv
// Fixed-depth shift register used to align tags and write data with the ZBT pipeline.
module vga_mem_fetch_delay #(
    parameter int N   = 2,
    parameter int LOG = 36
) (
    input  logic           clock,
    input  logic           reset_b,
    input  logic [LOG-1:0] d,
    output logic [LOG-1:0] q
);

    logic [LOG-1:0] stage [N];

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < N; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/vga_mem_fetch.sv
// ZBT port: VGA pixel reads with strict priority, NTSC capture writes in idle cycles,
// and a double buffer that flips only during vertical blank.
module vga_mem_fetch
    import vga_mem_fetch_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int LINE_WORDS  = 320,
    parameter int BUF_BIT     = 18
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  vga_flag,
    input  logic [LOG_HCOUNT-1:0] clocked_hcount,
    input  logic [LOG_VCOUNT-1:0] clocked_vcount,
    output logic [LOG_MEM-1:0]    vga_pixel,
    output logic                  done_vga,
    input  logic                  ntsc_flag,
    input  logic [ZBT_AW-1:0]     ntsc_addr,
    input  logic [LOG_MEM-1:0]    ntsc_data,
    output logic                  done_ntsc,
    input  logic                  frame_flag,
    output logic [ZBT_AW-1:0]     mem_addr,
    output logic                  mem_we_b,
    output logic [LOG_MEM-1:0]    mem_write_data,
    input  logic [LOG_MEM-1:0]    mem_read_data
);

    logic              vga_prev_p0;
    logic              disp_sel_p0;
    logic              swap_pending_p0;
    logic              read_trig;
    logic              in_range;
    logic              wr_accept;
    logic              swap_now;
    logic [ZBT_AW-1:0] disp_base;
    logic [ZBT_AW-1:0] cap_base;
    logic [ZBT_AW-1:0] rd_addr;
    logic [ZBT_AW-1:0] wr_addr;
    slot_tag_t         tag_p0;
    slot_tag_t         tag_pn;
    logic [LOG_MEM-1:0] wdata_p0;
    logic [LOG_MEM-1:0] wdata_pn;

    // Request decode: reads win; a write waits out the cycle its own done pulse is high.
    assign read_trig = vga_flag & ~vga_prev_p0;
    assign in_range  = (clocked_hcount < LOG_HCOUNT'(SCREEN_W)) &&
                       (clocked_vcount < LOG_VCOUNT'(SCREEN_H));
    assign wr_accept = ntsc_flag & ~read_trig & ~done_ntsc;
    assign swap_now  = read_trig & swap_pending_p0 &
                       (clocked_vcount >= LOG_VCOUNT'(SCREEN_H));

    assign disp_base = ZBT_AW'(disp_sel_p0) << BUF_BIT;
    assign cap_base  = ZBT_AW'(~disp_sel_p0) << BUF_BIT;
    assign rd_addr   = disp_base + line_base(clocked_vcount, LINE_WORDS) +
                       ZBT_AW'(clocked_hcount[9:1]);
    assign wr_addr   = cap_base + ntsc_addr;

    assign tag_p0.valid   = read_trig | wr_accept;
    assign tag_p0.is_read = read_trig;
    assign tag_p0.zero    = read_trig & ~in_range;
    assign wdata_p0       = wr_accept ? ntsc_data : '0;

    // Address phase
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            vga_prev_p0     <= 1'b1;
            mem_addr        <= '0;
            mem_we_b        <= 1'b1;
            done_ntsc       <= 1'b0;
            disp_sel_p0     <= 1'b0;
            swap_pending_p0 <= 1'b0;
        end else begin
            vga_prev_p0 <= vga_flag;
            mem_we_b    <= ~wr_accept;
            done_ntsc   <= wr_accept;
            if (read_trig && in_range)
                mem_addr <= rd_addr;
            else if (wr_accept)
                mem_addr <= wr_addr;
            if (swap_now) begin
                disp_sel_p0     <= ~disp_sel_p0;
                swap_pending_p0 <= frame_flag;
            end else if (frame_flag) begin
                swap_pending_p0 <= 1'b1;
            end
        end
    end

    vga_mem_fetch_delay #(.N(MEM_LATENCY + 1), .LOG($bits(slot_tag_t))) u_tag_pipe (
        .clock   (clock),
        .reset_b (reset_b),
        .d       (tag_p0),
        .q       (tag_pn)
    );

    vga_mem_fetch_delay #(.N(MEM_LATENCY), .LOG(LOG_MEM)) u_wdata_pipe (
        .clock   (clock),
        .reset_b (reset_b),
        .d       (wdata_p0),
        .q       (wdata_pn)
    );

    // Data phase
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            vga_pixel      <= '0;
            done_vga       <= 1'b0;
            mem_write_data <= '0;
        end else begin
            mem_write_data <= wdata_pn;
            done_vga       <= tag_pn.valid & tag_pn.is_read;
            if (tag_pn.valid && tag_pn.is_read)
                vga_pixel <= tag_pn.zero ? '0 : mem_read_data;
        end
    end

endmodule

// File: tb/tb_vga_mem_fetch.sv
// Directed bench for vga_mem_fetch with a two-cycle ZBT read model.
module tb_vga_mem_fetch;

    logic        clock = 1'b0;
    logic        reset_b;
    logic        vga_flag;
    logic [10:0] clocked_hcount;
    logic [9:0]  clocked_vcount;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        ntsc_flag;
    logic [18:0] ntsc_addr;
    logic [35:0] ntsc_data;
    logic        done_ntsc;
    logic        frame_flag;
    logic [18:0] mem_addr;
    logic        mem_we_b;
    logic [35:0] mem_write_data;
    logic [35:0] mem_read_data = '0;
    logic [18:0] zbt_a1 = '0;

    int n_tests = 0;
    int n_fail  = 0;

    vga_mem_fetch dut (
        .clock          (clock),
        .reset_b        (reset_b),
        .vga_flag       (vga_flag),
        .clocked_hcount (clocked_hcount),
        .clocked_vcount (clocked_vcount),
        .vga_pixel      (vga_pixel),
        .done_vga       (done_vga),
        .ntsc_flag      (ntsc_flag),
        .ntsc_addr      (ntsc_addr),
        .ntsc_data      (ntsc_data),
        .done_ntsc      (done_ntsc),
        .frame_flag     (frame_flag),
        .mem_addr       (mem_addr),
        .mem_we_b       (mem_we_b),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clock = ~clock;

    function automatic logic [35:0] zbt_word(input logic [18:0] a);
        if (a == 19'h00282)
            return 36'h123456789;
        return {a[16:0], a};
    endfunction

    // Read data appears two cycles after the address is registered.
    always @(posedge clock) begin
        zbt_a1        <= mem_addr;
        mem_read_data <= zbt_word(zbt_a1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_read(input logic [10:0] h, input logic [9:0] v);
        @(negedge clock);
        clocked_hcount = h;
        clocked_vcount = v;
        vga_flag       = 1'b1;
        step();
    endtask

    task automatic finish_read(input string tag, input logic [35:0] exp_pix);
        int lat   = 0;
        int n_don = 0;
        logic [35:0] pix = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            vga_flag = 1'b0;
            step();
            if (done_vga) begin
                n_don++;
                if (lat == 0) begin
                    lat = i;
                    pix = vga_pixel;
                end
            end
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_pulses"}, n_don, 1);
        check({tag, "_pix"}, pix, exp_pix);
        check({tag, "_hold"}, vga_pixel, exp_pix);
    endtask

    task automatic write_only(input string tag, input logic [18:0] a, input logic [35:0] d,
                              input logic [18:0] exp_addr);
        @(negedge clock);
        ntsc_flag = 1'b1;
        ntsc_addr = a;
        ntsc_data = d;
        step();
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_we"}, mem_we_b, 0);
        check({tag, "_done"}, done_ntsc, 1);
        @(negedge clock);
        ntsc_flag = 1'b0;
        step();
        check({tag, "_we_off"}, mem_we_b, 1);
        check({tag, "_done_off"}, done_ntsc, 0);
        check({tag, "_wd_early"}, mem_write_data, 0);
        step();
        check({tag, "_wd"}, mem_write_data, d);
        step();
        check({tag, "_wd_after"}, mem_write_data, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset_b        = 1'b0;
        vga_flag       = 1'b1;
        clocked_hcount = '0;
        clocked_vcount = '0;
        ntsc_flag      = 1'b0;
        ntsc_addr      = '0;
        ntsc_data      = '0;
        frame_flag     = 1'b0;

        step();
        step();
        check("rst_addr", mem_addr, 0);
        check("rst_we", mem_we_b, 1);
        check("rst_pix", vga_pixel, 0);
        check("rst_done_vga", done_vga, 0);
        check("rst_done_ntsc", done_ntsc, 0);
        check("rst_wd", mem_write_data, 0);

        // Flag already high at release must not count as a request.
        @(negedge clock);
        reset_b = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done_vga) cnt++;
        end
        check("no_req_from_reset", cnt, 0);
        @(negedge clock);
        vga_flag = 1'b0;
        step();

        issue_read(11'd5, 10'd2);
        check("rdA_addr", mem_addr, 19'h00282);
        check("rdA_we", mem_we_b, 1);
        finish_read("rdA", 36'h123456789);

        issue_read(11'd700, 10'd10);
        check("rdB_addr", mem_addr, 19'h00282);
        finish_read("rdB", 36'h0);

        // Read and write arrive together: read first, write next cycle.
        @(negedge clock);
        clocked_hcount = 11'd4;
        clocked_vcount = 10'd1;
        vga_flag       = 1'b1;
        ntsc_flag      = 1'b1;
        ntsc_addr      = 19'h00010;
        ntsc_data      = 36'hABCDE1234;
        step();
        check("col_rd_addr", mem_addr, 19'h00142);
        check("col_rd_we", mem_we_b, 1);
        check("col_rd_dn", done_ntsc, 0);
        @(negedge clock);
        vga_flag = 1'b0;
        step();
        check("col_wr_addr", mem_addr, 19'h40010);
        check("col_wr_we", mem_we_b, 0);
        check("col_wr_dn", done_ntsc, 1);
        check("col_wd_k1", mem_write_data, 0);
        @(negedge clock);
        ntsc_flag = 1'b0;
        step();
        check("col_we_off", mem_we_b, 1);
        check("col_dn_once", done_ntsc, 0);
        check("col_wd_k2", mem_write_data, 0);
        step();
        check("col_wd", mem_write_data, 36'hABCDE1234);
        check("col_done_vga", done_vga, 1);
        check("col_pix", vga_pixel, 36'h00A100142);
        step();
        check("col_done_vga_off", done_vga, 0);
        repeat (3) step();

        write_only("wr_wrap", 19'h40005, 36'h0FEDCBA98, 19'h00005);

        // Swap only applies on a vertical-blank read.
        @(negedge clock);
        frame_flag = 1'b1;
        @(negedge clock);
        frame_flag = 1'b0;
        issue_read(11'd0, 10'd100);
        check("sw_v100_addr", mem_addr, 19'h07D00);
        finish_read("sw_v100", 36'h3E8007D00);
        issue_read(11'd0, 10'd490);
        finish_read("sw_v490", 36'h0);
        issue_read(11'd0, 10'd0);
        check("sw_new_addr", mem_addr, 19'h40000);
        finish_read("sw_new", 36'h000040000);
        write_only("sw_wr", 19'h00010, 36'h111122223, 19'h00010);

        issue_read(11'd0, 10'd490);
        finish_read("nosw_v490", 36'h0);
        issue_read(11'd0, 10'd0);
        check("nosw_addr", mem_addr, 19'h40000);
        finish_read("nosw", 36'h000040000);

        // Reset while a read is in flight.
        issue_read(11'd5, 10'd2);
        @(negedge clock);
        reset_b  = 1'b0;
        vga_flag = 1'b0;
        #1;
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_we", mem_we_b, 1);
        check("mid_rst_pix", vga_pixel, 0);
        check("mid_rst_done", done_vga, 0);
        @(negedge clock);
        reset_b = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done_vga) cnt++;
        end
        check("mid_rst_no_done", cnt, 0);
        issue_read(11'd2, 10'd0);
        check("post_rst_addr", mem_addr, 19'h00001);
        finish_read("post_rst", 36'h000080001);
        write_only("post_rst_wr", 19'h00003, 36'h000000055, 19'h40003);

        issue_read(11'd639, 10'd479);
        check("edge_max_addr", mem_addr, 19'h257FF);
        finish_read("edge_max", 36'h2BFFA57FF);
        issue_read(11'd640, 10'd0);
        check("edge_h640_addr", mem_addr, 19'h257FF);
        finish_read("edge_h640", 36'h0);
        issue_read(11'd0, 10'd480);
        finish_read("edge_v480", 36'h0);

        // Held request level yields a single read.
        @(negedge clock);
        clocked_hcount = 11'd0;
        clocked_vcount = 10'd1;
        vga_flag       = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_vga) cnt++;
        end
        @(negedge clock);
        vga_flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done_vga) cnt++;
        end
        check("held_pulses", cnt, 1);
        check("held_addr", mem_addr, 19'h00140);
        check("held_pix", vga_pixel, 36'h00A000140);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
